// File: rtl/store_data_aligner_if.sv
// Store request / memory write bus between a requester and the store data aligner.
interface store_data_aligner_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       data_i;
  logic [1:0]        size_i;
  logic              mem_valid_o;
  logic              mem_ready_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_be_o;
  logic              misalign_o;
  logic [ADDR_W-1:0] misalign_addr_o;

  // Aligner side.
  modport slave (
    input  req_valid_i, addr_i, data_i, size_i, mem_ready_i,
    output req_ready_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_be_o,
           misalign_o, misalign_addr_o
  );

  // Requester / memory side.
  modport master (
    output req_valid_i, addr_i, data_i, size_i, mem_ready_i,
    input  req_ready_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_be_o,
           misalign_o, misalign_addr_o
  );
endinterface

// File: rtl/store_data_aligner.sv
// Store data aligner: replicates SB/SH/SW data onto little-endian byte lanes, builds byte
// enables, queues legal writes in a small FIFO and flags misaligned or reserved stores.
module store_data_aligner #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  store_data_aligner_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0]       wdata_q [DEPTH];
  logic [3:0]        be_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;

  logic              legal;
  logic [31:0]       fmt_wdata;
  logic [3:0]        fmt_be;
  logic              accept, push, pop;
  logic [1:0]        offset;

  assign offset = bus.addr_i[1:0];

  // Lane formatting and legality of the incoming request.
  always_comb begin
    legal     = 1'b0;
    fmt_wdata = bus.data_i;
    fmt_be    = 4'b0000;
    case (bus.size_i)
      2'b00: begin
        legal     = 1'b1;
        fmt_wdata = {4{bus.data_i[7:0]}};
        fmt_be    = 4'b0001 << offset;
      end
      2'b01: begin
        legal     = ~offset[0];
        fmt_wdata = {2{bus.data_i[15:0]}};
        fmt_be    = 4'b0011 << offset;
      end
      2'b10: begin
        legal     = (offset == 2'b00);
        fmt_wdata = bus.data_i;
        fmt_be    = 4'b1111;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Ready depends only on occupancy, so a pop never frees a slot in the same cycle.
  assign bus.req_ready_o = (count_q != CntW'(DEPTH));
  assign accept          = bus.req_valid_i & bus.req_ready_o;
  assign push            = accept & legal;
  assign bus.mem_valid_o = (count_q != '0);
  assign pop             = bus.mem_valid_o & bus.mem_ready_i;

  // Head outputs come straight from storage and read zero while empty.
  assign bus.mem_addr_o  = bus.mem_valid_o ? addr_q[rptr_q]  : '0;
  assign bus.mem_wdata_o = bus.mem_valid_o ? wdata_q[rptr_q] : '0;
  assign bus.mem_be_o    = bus.mem_valid_o ? be_q[rptr_q]    : '0;

  assign bus.misalign_o      = misalign_q;
  assign bus.misalign_addr_o = misalign_addr_q;

  // Occupancy and error-report next state.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    misalign_d      = accept & ~legal;
    misalign_addr_d = (accept & ~legal) ? bus.addr_i : misalign_addr_q;
  end

  // FIFO storage, pointers and error registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
      end
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      if (push) begin
        addr_q[wptr_q]  <= {bus.addr_i[ADDR_W-1:2], 2'b00};
        wdata_q[wptr_q] <= fmt_wdata;
        be_q[wptr_q]    <= fmt_be;
        wptr_q          <= (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      end
      count_q         <= count_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end
endmodule

// File: tb/tb_store_data_aligner.sv
// Bench for store_data_aligner: directed scenarios then random traffic, checked each cycle
// against a queue-based reference model.
module tb_store_data_aligner;
  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  ent_t q[$];
  logic        exp_mis;
  logic [31:0] exp_maddr;

  store_data_aligner_if #(.ADDR_W(32)) bus ();

  store_data_aligner #(.ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t h;
    chk("req_ready", {31'd0, bus.req_ready_o}, {31'd0, q.size() != DEPTH});
    chk("mem_valid", {31'd0, bus.mem_valid_o}, {31'd0, q.size() != 0});
    if (q.size() != 0) h = q[0];
    else begin
      h.addr = 0; h.wdata = 0; h.be = 0;
    end
    chk("mem_addr", bus.mem_addr_o, h.addr);
    chk("mem_wdata", bus.mem_wdata_o, h.wdata);
    chk("mem_be", {28'd0, bus.mem_be_o}, {28'd0, h.be});
    chk("misalign", {31'd0, bus.misalign_o}, {31'd0, exp_mis});
    chk("misalign_addr", bus.misalign_addr_o, exp_maddr);
  endtask

  // One clock: predict from the current inputs and the model, then check after the edge.
  task automatic cycle(output bit acc);
    int unsigned n, o, sz;
    bit   pop, legal;
    ent_t e, tmp;
    n   = q.size();
    acc = bus.req_valid_i && (n != DEPTH);
    pop = (n != 0) && bus.mem_ready_i;
    o   = bus.addr_i % 4;
    sz  = bus.size_i;
    legal = (sz == 0) || (sz == 1 && o % 2 == 0) || (sz == 2 && o == 0);
    e.addr = bus.addr_i - o;
    if (sz == 0) begin
      e.wdata = (bus.data_i % 256) * 32'h0101_0101;
      e.be    = 4'(1 << o);
    end else if (sz == 1) begin
      e.wdata = (bus.data_i % 65536) * 32'h0001_0001;
      e.be    = 4'(3 << o);
    end else begin
      e.wdata = bus.data_i;
      e.be    = 4'hF;
    end
    @(posedge clk);
    #1;
    if (pop) tmp = q.pop_front();
    if (acc && legal) q.push_back(e);
    exp_mis = acc && !legal;
    if (exp_mis) exp_maddr = bus.addr_i;
    check_all();
  endtask

  task automatic idle(input int cycles);
    bit acc;
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < cycles; i++) cycle(acc);
  endtask

  // Hold a request until it is accepted (bounded).
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bit acc;
    bit done;
    done = 0;
    bus.req_valid_i = 1'b1;
    bus.addr_i      = a;
    bus.data_i      = d;
    bus.size_i      = s;
    for (int i = 0; i < 10 && !done; i++) begin
      cycle(acc);
      done = acc;
    end
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted addr=%h", a);
    end
    bus.req_valid_i = 1'b0;
  endtask

  initial begin
    bit acc;
    checks = 0;
    failures = 0;
    exp_mis = 0;
    exp_maddr = 0;
    rst = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.addr_i      = '0;
    bus.data_i      = '0;
    bus.size_i      = '0;
    bus.mem_ready_i = 1'b0;
    #1 rst = 1'b1;
    #20;
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("ready_after_reset", {31'd0, bus.req_ready_o}, 32'd1);

    // 1: SB at 0x13 -> lane 3
    send(32'h13, 32'hAABB_CCDD, 2'b00);
    chk("sb_valid", {31'd0, bus.mem_valid_o}, 32'd1);
    chk("sb_addr", bus.mem_addr_o, 32'h10);
    chk("sb_wdata", bus.mem_wdata_o, 32'hDDDD_DDDD);
    chk("sb_be", {28'd0, bus.mem_be_o}, 32'h8);
    bus.mem_ready_i = 1'b1;
    idle(1);

    // 2: SH at 0x22, SW at 0x40
    bus.mem_ready_i = 1'b0;
    send(32'h22, 32'h1234_ABCD, 2'b01);
    chk("sh_wdata", bus.mem_wdata_o, 32'hABCD_ABCD);
    chk("sh_be", {28'd0, bus.mem_be_o}, 32'hC);
    bus.mem_ready_i = 1'b1;
    idle(1);
    bus.mem_ready_i = 1'b0;
    send(32'h40, 32'hCAFE_F00D, 2'b10);
    chk("sw_wdata", bus.mem_wdata_o, 32'hCAFE_F00D);
    chk("sw_be", {28'd0, bus.mem_be_o}, 32'hF);
    bus.mem_ready_i = 1'b1;
    idle(1);

    // 3: illegal stores
    send(32'h41, 32'h1111_2222, 2'b10);
    chk("sw_mis_pulse", {31'd0, bus.misalign_o}, 32'd1);
    chk("sw_mis_addr", bus.misalign_addr_o, 32'h41);
    chk("sw_mis_noenq", {31'd0, bus.mem_valid_o}, 32'd0);
    idle(1);
    chk("mis_one_cycle", {31'd0, bus.misalign_o}, 32'd0);
    chk("mis_addr_hold", bus.misalign_addr_o, 32'h41);
    send(32'h23, 32'h3333_4444, 2'b01);
    chk("sh_mis_addr", bus.misalign_addr_o, 32'h23);
    send(32'h50, 32'h5555_6666, 2'b11);
    chk("rsv_mis_addr", bus.misalign_addr_o, 32'h50);
    idle(1);

    // 4: backpressure with three legal stores, then drain
    bus.mem_ready_i = 1'b0;
    send(32'h100, 32'h0000_0001, 2'b10);
    send(32'h104, 32'h0000_0002, 2'b10);
    chk("full_ready_low", {31'd0, bus.req_ready_o}, 32'd0);
    bus.req_valid_i = 1'b1;
    bus.addr_i = 32'h108;
    bus.data_i = 32'h0000_0003;
    bus.size_i = 2'b10;
    cycle(acc);
    cycle(acc);
    chk("head_stable", bus.mem_wdata_o, 32'h1);
    bus.mem_ready_i = 1'b1;
    send(32'h108, 32'h0000_0003, 2'b10);
    idle(4);

    // 5: push and pop on the same edge with one entry queued
    bus.mem_ready_i = 1'b0;
    send(32'h200, 32'hAAAA_0001, 2'b10);
    bus.mem_ready_i = 1'b1;
    send(32'h204, 32'hAAAA_0002, 2'b10);
    chk("pp_head", bus.mem_wdata_o, 32'hAAAA_0002);
    idle(2);

    // 6: asynchronous reset with two entries queued
    bus.mem_ready_i = 1'b0;
    send(32'h300, 32'hBBBB_0001, 2'b10);
    send(32'h304, 32'hBBBB_0002, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, bus.mem_valid_o}, 32'd0);
    q.delete();
    exp_mis = 0;
    exp_maddr = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();
    bus.mem_ready_i = 1'b1;
    send(32'h400, 32'hCCCC_0001, 2'b10);
    chk("post_rst_head", bus.mem_wdata_o, 32'hCCCC_0001);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.req_valid_i = 1'($urandom_range(0, 1));
      bus.addr_i      = $urandom_range(0, 255);
      bus.data_i      = $urandom;
      bus.size_i      = 2'($urandom_range(0, 3));
      bus.mem_ready_i = 1'($urandom_range(0, 1));
      cycle(acc);
    end
    bus.mem_ready_i = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
